led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver and successor to the single free-running toggle LED. A shared prescaler derives a slow tick from the 50 MHz PL clock. Each channel independently runs OFF, ON, BLINK (programmable half-period) or ONESHOT (retriggerable timed pulse). Sits between top-level control logic (dip/buttons) and the board LED pins; outputs are active-high.

Parameters:
CHANNELS, 10, number of LED channels (1..32)
PRESCALE, 50000, clk cycles per tick (>=1); 50000 gives a 1 kHz tick at 50 MHz
PERIOD_W, 8, width of the period field in ticks
PWM_W, 4, width of the duty field and PWM counter (used only with LED_PWM_EN)

Ports:
clk  input  1  PL clock, 50 MHz, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  1 = prescaler runs; 0 = tick-based timing frozen
mode  input  2*CHANNELS  per-channel mode, channel i uses bits [2i+1:2i]; 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
period  input  PERIOD_W  shared half-period (BLINK) or pulse length (ONESHOT), in ticks
trigger  input  CHANNELS  per-channel ONESHOT start, rising-edge sensitive
duty  input  PWM_W  brightness; ignored without LED_PWM_EN
led  output  CHANNELS  LED drive, registered
tick  output  1  one-cycle prescaler strobe, registered

Behaviour:
- Reset (rst=1 at a clk edge): led=0, tick=0, prescaler=0, all channel counters=0, registered mode and trigger copies=0. Reset overrides everything, including mid-pulse and mid-blink.
- Prescaler: counts 0..PRESCALE-1 while enable=1 and wraps to 0. tick=1 for exactly one cycle on the cycle after the count reaches PRESCALE-1. With enable=0 the count holds and tick=0. PRESCALE=1 gives tick=1 on every enabled cycle.
- period=0 is treated as 1.
- Latency: every led change is visible one clk after the causing event (mode change, tick, or trigger edge).
- Mode change: each channel registers its mode. When the registered value differs from the input, the channel counter clears and led takes the new mode's initial value on the next cycle.
- OFF: led=0; counter held at 0.
- ON: led=1 (or the PWM waveform, see Optional Feature); counter held at 0.
- BLINK:
  - Initial led=1.
  - On each tick: if counter==period-1, counter=0 and led toggles; otherwise counter+1.
  - Full cycle = 2*period ticks.
- ONESHOT:
  - Idle led=0.
  - A trigger rising edge (trigger & ~trigger_q) loads counter=period and sets led=1.
  - Each tick decrements the counter; when the decrement reaches 0, led=0.
  - Retrigger while active reloads the counter (pulse extends).
  - If a trigger edge and a tick coincide, the load wins.
  - The trigger level alone does nothing.
- enable=0: BLINK and ONESHOT counters and led freeze. OFF and ON still respond to mode changes. Trigger edges while disabled still load and set led=1.
- Counters are PERIOD_W bits; no overflow is possible by construction.

Optional Feature:
Macro LED_PWM_EN.
- Defined:
  - A free-running PWM_W-bit counter advances every clk cycle, including when enable=0; it is cleared by rst.
  - The "lit" level in ON, in the high phase of BLINK, and during an active ONESHOT becomes pwm_cnt < duty.
  - duty=all-ones forces constant 1; duty=0 forces 0.
- Undefined: no PWM counter exists, duty is ignored, and the lit level is constant 1.

Decomposition:
- Package led_pkg: mode encodings (MODE_OFF=2'b00, MODE_ON=2'b01, MODE_BLINK=2'b10, MODE_ONESHOT=2'b11) and the mode typedef.
- Sub-module led_channel: one channel's mode register, trigger edge detect, counter and led flop. It receives tick, period, lit level, enable and rst.
- Top level: the prescaler, the optional PWM counter, and a generate loop instantiating led_channel CHANNELS times.

Test Plan (CHANNELS=4, PRESCALE=4, PERIOD_W=4, PWM_W=4):
1. Reset and prescaler: rst=1 for 3 cycles, then 0, enable=1 -> led=4'b0000 and tick=0 during reset; first tick 4 cycles after release, then every 4 cycles exactly; with enable=0, tick stays 0 and the count resumes where it stopped.
2. BLINK: ch0 mode=10, period=3 -> led[0]=1 immediately after the mode change, then toggles every 3 ticks (12 cycles); period=0 -> toggles every tick (4 cycles).
3. ONESHOT: ch1 mode=11, period=2, one-cycle trigger[1] pulse -> led[1]=1 the next cycle and returns to 0 on the 2nd subsequent tick; holding trigger high produces no second pulse; a second edge mid-pulse extends the pulse by a full 2 ticks.
4. Freeze and mode change: enable=0 mid-BLINK -> led[0] and its counter hold for 20 cycles, and resume the same phase when enable=1; BLINK->OFF->BLINK -> led=0, then restarts at 1 with counter 0.
5. Simultaneous events: a trigger edge coincides with a tick on an active oneshot -> reload wins and the counter equals period; rst asserted mid-pulse -> led=0 on the next cycle.
6. LED_PWM_EN: ch2 ON with duty=4 -> led[2] high for 4 of every 16 cycles; duty=15 -> constant 1; duty=0 -> constant 0. Without the macro, duty=4 gives constant 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: the channel mode encoding
// and the LED level each mode starts with after a mode change.
// Latency: n/a (declarations only). Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    // Lit/unlit state a channel takes on the cycle after entering a mode.
    function automatic logic mode_init_on(input mode_t m);
        return (m == MODE_ON) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode register, trigger edge detect, tick counter, LED flop.
// Latency: led updates one clk after a mode change, consumed tick or trigger edge.
// Backpressure: none; tick and trigger are consumed on the cycle they arrive.
//
// Ports: clk/rst (sync, active-high), enable (freezes tick timing), tick
// (prescaler strobe), mode (2-bit channel mode), period (half-period / pulse
// length in ticks, 0 treated as 1), trigger (oneshot start, rising edge),
// lit (level used while the channel is "on"), led (registered drive).
module led_channel
    import led_pkg::*;
#(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                tick,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                trigger,
    input  logic                lit,
    output logic                led
);

    mode_t               mode_in;
    mode_t               mode_q;
    logic                trig_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                on_q;     // blink phase / oneshot active, independent of PWM
    logic                on_d;
    logic [PERIOD_W-1:0] per_eff;
    logic [PERIOD_W-1:0] per_m1;
    logic                step;
    logic                trig_edge;

    assign mode_in   = mode_t'(mode);
    assign per_eff   = (period == '0) ? PERIOD_W'(1) : period;
    assign per_m1    = per_eff - PERIOD_W'(1);
    assign step      = tick & enable;
    assign trig_edge = trigger & ~trig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            trig_q <= 1'b0;
            cnt_q  <= '0;
            on_q   <= 1'b0;
            led    <= 1'b0;
        end else begin
            mode_q <= mode_in;
            trig_q <= trigger;
            cnt_q  <= cnt_d;
            on_q   <= on_d;
            led    <= on_d & lit;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (mode_in != mode_q) begin
            // A mode change restarts the channel from the new mode's initial state.
            cnt_d = '0;
            on_d  = mode_init_on(mode_in);
        end else begin
            unique case (mode_q)
                MODE_OFF: begin
                    cnt_d = '0;
                    on_d  = 1'b0;
                end
                MODE_ON: begin
                    cnt_d = '0;
                    on_d  = 1'b1;
                end
                MODE_BLINK: begin
                    if (step) begin
                        // >= so that shrinking period mid-count still wraps promptly.
                        if (cnt_q >= per_m1) begin
                            cnt_d = '0;
                            on_d  = ~on_q;
                        end else begin
                            cnt_d = cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    // A trigger edge beats a coincident tick: the pulse is reloaded.
                    if (trig_edge) begin
                        cnt_d = per_eff;
                        on_d  = 1'b1;
                    end else if (step && on_q) begin
                        cnt_d = cnt_q - PERIOD_W'(1);
                        if (cnt_q == PERIOD_W'(1)) begin
                            on_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler tick, per-channel OFF/ON/BLINK/ONESHOT.
// Latency: tick and led are registered; led follows its cause by one clk.
// Backpressure: none; all inputs are sampled every cycle.
//
// Ports: clk, rst (sync, active-high), enable (runs the prescaler), mode
// (2 bits per channel), period (shared, in ticks), trigger (per-channel
// oneshot start), duty (PWM brightness), led (active-high), tick (strobe).
// Build option: define LED_PWM_EN to modulate the lit level with duty.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CHANNELS = 10,
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 8,
    parameter int PWM_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [CHANNELS-1:0]   trigger,
    input  logic [PWM_W-1:0]      duty,
    output logic [CHANNELS-1:0]   led,
    output logic                  tick
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;
    logic            lit;

    // Prescaler: holds its count while disabled so timing resumes in phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (enable) begin
            tick   <= (ps_cnt == PS_LAST);
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
        end else begin
            tick   <= 1'b0;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    // Free-running: brightness keeps working while tick timing is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // All-ones duty must be fully on, which pwm_cnt < duty alone cannot reach.
    assign lit = (duty == '1) || (pwm_cnt < duty);
`else
    logic unused_duty;

    // duty has no effect in this build.
    assign unused_duty = ^duty;
    assign lit         = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .tick    (tick),
            .mode    (mode[2*i +: 2]),
            .period  (period),
            .trigger (trigger[i]),
            .lit     (lit),
            .led     (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

    localparam int CH = 4;
    localparam int PS = 4;
    localparam int PW = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [2*CH-1:0] mode;
    logic [PW-1:0]   period;
    logic [CH-1:0]   trigger;
    logic [DW-1:0]   duty;
    logic [CH-1:0]   led;
    logic            tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CHANNELS (CH),
        .PRESCALE (PS),
        .PERIOD_W (PW),
        .PWM_W    (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .period  (period),
        .trigger (trigger),
        .duty    (duty),
        .led     (led),
        .tick    (tick)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is seen high (tick not yet consumed by channels).
    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (tick !== 1'b1 && k < 20);
        check(tag, int'(tick), 1);
    endtask

    // Cycles until led[ch] changes; -1 on timeout.
    task automatic count_toggle(input int ch, output int n);
        logic v;
        v = led[ch];
        n = 0;
        do begin
            cyc();
            n++;
        end while (led[ch] === v && n < 40);
        if (led[ch] === v) n = -1;
    endtask

    initial begin
        int n;
        int changes;
        int ticks;
        logic v;
        int exp_pwm;

        rst = 1'b1; enable = 1'b1; mode = '0; period = '0; trigger = '0; duty = '0;

        // 1. reset and prescaler
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_led", int'(led), 0);
            check("rst_tick", int'(tick), 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check($sformatf("tick_c%0d", i), int'(tick), int'(i % 4 == 0));
        end
        cyc(); check("tick_pre_dis1", int'(tick), 0);
        cyc(); check("tick_pre_dis2", int'(tick), 0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); check("tick_disabled", int'(tick), 0);
        end
        enable = 1'b1;
        cyc(); check("tick_resume1", int'(tick), 0);
        cyc(); check("tick_resume2", int'(tick), 1);

        // 2. BLINK on ch0
        cyc();
        mode[1:0] = 2'b10; period = 4'd3;
        cyc(); check("blink_init", int'(led[0]), 1);
        wait_tick("blink_t1"); wait_tick("blink_t2"); wait_tick("blink_t3");
        check("blink_before_toggle", int'(led[0]), 1);
        cyc(); check("blink_toggle", int'(led[0]), 0);
        count_toggle(0, n); check("blink_p3_cycles", n, 12);
        period = 4'd0;
        count_toggle(0, n); check("blink_p0_cycles_a", n, 4);
        count_toggle(0, n); check("blink_p0_cycles_b", n, 4);

        // 3. ONESHOT on ch1
        period = 4'd2; mode[3:2] = 2'b11;
        cyc(); check("os_idle", int'(led[1]), 0);
        wait_tick("os_sync"); cyc();
        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("os_start", int'(led[1]), 1);
        wait_tick("os_t1"); check("os_before_t1", int'(led[1]), 1);
        cyc(); check("os_after_t1", int'(led[1]), 1);
        wait_tick("os_t2"); cyc(); check("os_end", int'(led[1]), 0);

        trigger[1] = 1'b1; cyc(); check("os_hold_start", int'(led[1]), 1);
        wait_tick("os_hold_t1"); wait_tick("os_hold_t2");
        cyc(); check("os_hold_end", int'(led[1]), 0);
        changes = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (led[1] !== 1'b0) changes++;
        end
        check("os_level_no_retrig", changes, 0);
        trigger[1] = 1'b0; cyc();

        wait_tick("os_ext_sync"); cyc();
        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("os_ext_start", int'(led[1]), 1);
        wait_tick("os_ext_t1"); cyc();
        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("os_ext_retrig", int'(led[1]), 1);
        wait_tick("os_ext_t2"); cyc(); check("os_ext_hold", int'(led[1]), 1);
        wait_tick("os_ext_t3"); cyc(); check("os_ext_end", int'(led[1]), 0);

        // 4. freeze and mode change on ch0 (period=2)
        count_toggle(0, n); check("frz_sync", int'(n > 0), 1);
        v = led[0];
        enable = 1'b0;
        changes = 0; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (led[0] !== v) changes++;
            if (tick !== 1'b0) ticks++;
        end
        check("frz_led_held", changes, 0);
        check("frz_no_tick", ticks, 0);
        enable = 1'b1;
        count_toggle(0, n); check("frz_resume_cycles", n, 8);

        wait_tick("mc_sync"); cyc();
        mode[1:0] = 2'b00; cyc(); check("mc_off", int'(led[0]), 0);
        mode[1:0] = 2'b10; cyc(); check("mc_blink_restart", int'(led[0]), 1);
        count_toggle(0, n); check("mc_first_toggle", n, 6);

        // 5. coincident trigger/tick, reset mid-pulse (ch1, period=2)
        wait_tick("co_sync"); cyc();
        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("co_start", int'(led[1]), 1);
        wait_tick("co_tick");
        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("co_reload", int'(led[1]), 1);
        wait_tick("co_t1"); cyc(); check("co_hold", int'(led[1]), 1);
        wait_tick("co_t2"); cyc(); check("co_end", int'(led[1]), 0);

        trigger[1] = 1'b1; cyc(); trigger[1] = 1'b0;
        check("rst_mid_start", int'(led[1]), 1);
        rst = 1'b1; cyc();
        check("rst_mid_led", int'(led), 0);
        check("rst_mid_tick", int'(tick), 0);
        rst = 1'b0;

        // 6. PWM brightness on ch2 ON
        mode = 8'b00_01_00_00; duty = 4'd4;
        cyc(); cyc();
`ifdef LED_PWM_EN
        exp_pwm = 4;
`else
        exp_pwm = 16;
`endif
        n = 0;
        for (int i = 0; i < 16; i++) begin cyc(); if (led[2] === 1'b1) n++; end
        check("pwm_duty4", n, exp_pwm);
        duty = 4'd15; cyc();
        n = 0;
        for (int i = 0; i < 16; i++) begin cyc(); if (led[2] === 1'b1) n++; end
        check("pwm_duty15", n, 16);
        duty = 4'd0; cyc();
`ifdef LED_PWM_EN
        exp_pwm = 0;
`else
        exp_pwm = 16;
`endif
        n = 0;
        for (int i = 0; i < 16; i++) begin cyc(); if (led[2] === 1'b1) n++; end
        check("pwm_duty0", n, exp_pwm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
